// File: rtl/nvdla_scan_pkg.sv
// Shared definitions for the scan chain sequencer: request op codes and FSM states.
package nvdla_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_OP_SHIFT    = 2'b00,
    SCAN_OP_CAPSHIFT = 2'b01,
    SCAN_OP_CAP      = 2'b10,
    SCAN_OP_RSVD     = 2'b11
  } scan_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAP,
    ST_SHIFT,
    ST_RESP
  } scan_state_e;

endpackage

// File: rtl/scan_chain_ctrl_sreg.sv
// Load/shift register (sr, MSB-first serial out) paired with the readback register (rd).
module scan_chain_ctrl_sreg #(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 shift,
  input  logic                 so,
  input  logic                 clr,
  output logic                 si,
  output logic [CHAIN_LEN-1:0] rd
);

  logic [CHAIN_LEN-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
      rd <= '0;
    end else begin
      if (load)
        sr <= load_data;
      else if (shift)
        sr <= {sr[CHAIN_LEN-2:0], 1'b0};
      if (clr)
        rd <= '0;
      else if (shift)
        rd <= {rd[CHAIN_LEN-2:0], so};
    end
  end

  // sr is a flop, so the serial input to the chain is registered as well
  assign si = sr[CHAIN_LEN-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan/configuration chain sequencer: optional capture, CHAIN_LEN-bit shift, readback response.
module scan_chain_ctrl
  import nvdla_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [CHAIN_LEN-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 chain_se,
  output logic                 chain_si,
  input  logic                 chain_so,
  output logic                 chain_clk_en,
  output logic                 busy
);

  scan_state_e      state, state_nxt;
  scan_op_e         op;
  logic [CNT_W-1:0] cnt;
  logic             accept, shift_en, rsp_done, cnt_last;
  logic [CHAIN_LEN-1:0] rd;

  assign cnt_last = (cnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    rsp_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          unique case (scan_op_e'(req_op))
            SCAN_OP_SHIFT:                state_nxt = ST_SHIFT;
            SCAN_OP_CAPSHIFT, SCAN_OP_CAP: state_nxt = ST_CAP;
            default:                      state_nxt = ST_RESP;
          endcase
        end
      end
      ST_CAP:   state_nxt = (op == SCAN_OP_CAPSHIFT) ? ST_SHIFT : ST_RESP;
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_last)
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Chain controls are registered from the next state so they line up with the state cycle
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      op           <= SCAN_OP_SHIFT;
      cnt          <= '0;
      rsp_err      <= 1'b0;
      chain_se     <= 1'b0;
      chain_clk_en <= 1'b0;
    end else begin
      if (accept) begin
        op      <= scan_op_e'(req_op);
        rsp_err <= (scan_op_e'(req_op) == SCAN_OP_RSVD);
      end else if (rsp_done) begin
        rsp_err <= 1'b0;
      end
      if (shift_en)
        cnt <= cnt_last ? '0 : cnt + 1'b1;
      chain_se     <= (state_nxt == ST_SHIFT);
      chain_clk_en <= (state_nxt == ST_SHIFT) || (state_nxt == ST_CAP);
    end
  end

  scan_chain_ctrl_sreg #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_sreg (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .load      (accept),
    .load_data (req_data),
    .shift     (shift_en),
    .so        (chain_so),
    .clr       (rsp_done),
    .si        (chain_si),
    .rd        (rd)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign rsp_data  = rsp_valid ? rd : '0;

endmodule
